// File: rtl/cfg_frame_loader.sv
// Serial bitstream loader for the routing-tile configuration latches (wr_en + frame bus).
// Define CFG_PARITY_EN to receive and check one even-parity bit after every frame.
module cfg_frame_loader #(
    parameter int         NUM_TILES = 16,
    parameter int         FRAME_W   = 18,
    parameter int         WR_CYC    = 2,
    parameter logic [7:0] SYNC      = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 bit_i,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    output logic [NUM_TILES-1:0] wr_en,
    output logic [FRAME_W-1:0]   bits,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int CNT_W  = $clog2((FRAME_W > 8) ? FRAME_W : 8);
    localparam int WCNT_W = (WR_CYC > 1) ? $clog2(WR_CYC) : 1;

    typedef enum logic [3:0] {
        IDLE,
        SYNC_S,
        LOAD,
        PAR,
        SETUP,
        WRITE,
        HOLD,
        DONE,
        ERR
    } state_t;

    state_t               state;
    state_t               state_nx;

    logic                 accept;
    logic                 start_ok;
    logic [6:0]           sync_sr;
    logic [7:0]           sync_nx;
    logic [FRAME_W-1:0]   frame_sr;
    logic [FRAME_W-1:0]   frame_nx;
    logic [CNT_W-1:0]     bit_cnt;
    logic [TILE_W-1:0]    tile_idx;
    logic [WCNT_W-1:0]    wr_cnt;
    logic                 last_sync_bit;
    logic                 last_frame_bit;
    logic                 last_tile;
    logic                 write_end;

    logic [NUM_TILES-1:0] wr_en_nx;
    logic                 bit_ready_nx;
    logic                 busy_nx;
    logic                 done_nx;
    logic                 err_nx;

    assign accept         = bit_valid & bit_ready;
    assign start_ok       = start & ((state == IDLE) | (state == ERR));
    assign sync_nx        = {sync_sr, bit_i};
    assign frame_nx       = {frame_sr[FRAME_W-2:0], bit_i};
    assign last_sync_bit  = (bit_cnt == CNT_W'(7));
    assign last_frame_bit = (bit_cnt == CNT_W'(FRAME_W - 1));
    assign last_tile      = (tile_idx == TILE_W'(NUM_TILES - 1));
    assign write_end      = (wr_cnt == WCNT_W'(WR_CYC - 1));

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: the default at the top of each always_comb keeps the logic free of latches.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, ERR: begin
                if (start) begin
                    state_nx = SYNC_S;
                end
            end
            SYNC_S: begin
                if (accept && last_sync_bit) begin
                    state_nx = (sync_nx == SYNC) ? LOAD : ERR;
                end
            end
            LOAD: begin
                if (accept && last_frame_bit) begin
`ifdef CFG_PARITY_EN
                    state_nx = PAR;
`else
                    state_nx = SETUP;
`endif
                end
            end
`ifdef CFG_PARITY_EN
            PAR: begin
                if (accept) begin
                    state_nx = (^{frame_sr, bit_i} == 1'b0) ? SETUP : ERR;
                end
            end
`endif
            SETUP:   state_nx = WRITE;
            WRITE: begin
                if (write_end) begin
                    state_nx = HOLD;
                end
            end
            HOLD:    state_nx = last_tile ? DONE : LOAD;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so the latch enables
    // come straight from flops and never carry decode glitches.
    always_comb begin
        wr_en_nx     = '0;
        if (state_nx == WRITE) begin
            wr_en_nx = NUM_TILES'(1) << tile_idx;
        end
        bit_ready_nx = (state_nx == SYNC_S) || (state_nx == LOAD) || (state_nx == PAR);
        busy_nx      = (state_nx != IDLE) && (state_nx != ERR);
        done_nx      = (state_nx == DONE);
        err_nx       = (state_nx == ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en     <= '0;
            bit_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            wr_en     <= wr_en_nx;
            bit_ready <= bit_ready_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            err       <= err_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_sr  <= '0;
            frame_sr <= '0;
            bits     <= '0;
            bit_cnt  <= '0;
            tile_idx <= '0;
            wr_cnt   <= '0;
        end else begin
            if (start_ok) begin
                bit_cnt  <= '0;
                tile_idx <= '0;
            end else begin
                if (accept && (state == SYNC_S)) begin
                    bit_cnt <= last_sync_bit ? '0 : bit_cnt + 1'b1;
                end
                if (accept && (state == LOAD)) begin
                    bit_cnt <= last_frame_bit ? '0 : bit_cnt + 1'b1;
                end
                if ((state == HOLD) && !last_tile) begin
                    tile_idx <= tile_idx + 1'b1;
                end
            end

            if (accept && (state == SYNC_S)) begin
                sync_sr <= sync_nx[6:0];
            end
            if (accept && (state == LOAD)) begin
                frame_sr <= frame_nx;
            end

            // The frame bus changes only on entry to SETUP, a full cycle before wr_en rises.
            if ((state_nx == SETUP) && (state != SETUP)) begin
                bits <= (state == LOAD) ? frame_nx : frame_sr;
            end

            wr_cnt <= (state == WRITE) ? wr_cnt + 1'b1 : '0;
        end
    end

endmodule
